data_ram_arb: RTL and testbench
===============================

# data_ram_arb

Two-port arbiter and sequencer that shares the single 32-word × 32-bit data RAM between the CPU load/store path (port 0) and the debug/DMA path (port 1). It sits directly in front of the RAM's synchronous-write / asynchronous-read port, grants at most one access per cycle, and drives the RAM's byte write enables. Read data is captured and returned through a per-port response register with a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 5, RAM word-address width (32 words)
- DATA_W, 32, data width; the strobe is DATA_W/8 bits wide

Ports:
- clk  in  1  the only clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset
- pN_req  in  1  port N request valid (N = 0, 1)
- pN_we  in  1  1 = write, 0 = read
- pN_wstrb  in  4  byte write enables; ignored on reads
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_ready  out  1  request accepted this cycle (combinational)
- pN_rvalid  out  1  read response valid
- pN_rdata  out  DATA_W  read response data
- pN_rready  in  1  requester accepts the response
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM asynchronous read data

## Operation
- Eligibility: port N is eligible when pN_req=1 and it has no read response outstanding (pN_rvalid=0), or its response is being consumed this cycle (pN_rvalid & pN_rready).
- Each cycle, exactly one eligible port (or none) receives the grant. The granted port sees pN_ready=1 in the same cycle.
- RAM drive: on a granted write, ram_wen=pN_wstrb; otherwise ram_wen=4'b0000. ram_addr and ram_wdata follow the granted port, or port 0 when idle. The RAM is never written without a grant.
- Granted read: on the clock edge, ram_rdata is captured into pN_rdata and pN_rvalid is set to 1. The response holds, stable, until the edge on which pN_rready=1.
- Granted write: completes at that edge. No response is generated.
- Arbitration policy is set by the configuration macro. A last-grant register (1 bit) updates only on a grant.
- Same-port back-to-back: with rready=1 and a held response, a new read is granted in the cycle the old response is consumed, which sustains one read per cycle.
- Same-address hazard: a write on cycle t followed by a read on cycle t+1 (either port) returns the new data.
- Requests are not required to be stable before they are granted, but a requester holds its request until it sees ready. The block does not check this.

## Timing
- Reset (async assert, sync release): p0/p1_rvalid=0, p0/p1_rdata=0, last_grant=1 (port 0 wins first), ram_wen=0.
- Accept latency is 0 cycles (ready combinational from req). Read latency: rvalid rises 1 cycle after acceptance.
- Throughput: one access per cycle total across both ports.
- If resetn asserts while a response is pending, the response is discarded. A write granted in the same cycle as reset assertion does not occur.

## Configuration
- DATA_RAM_ARB_RR_EN defined: round-robin. On contention, the port not granted last wins.
- Not defined: fixed priority, where port 0 always wins contention. last_grant is still maintained but unused.

## Structure
- Shared package `data_ram_pkg`: ADDR_W, DATA_W, RAM_DEPTH=32, and the port index constants P_CPU=0, P_DBG=1.
- One natural sub-module, `data_ram_arb_resp`: the per-port response register (capture, hold, release on rready). It is instantiated twice.
- Grant logic and the RAM mux stay in the top module.

## Test plan
- After reset, no requests → rvalid=0 on both ports, ram_wen=0, rdata=0.
- p0 writes addr 3 = 0x12345678 with wstrb=4'hF, then p0 reads addr 3 → p0_rvalid one cycle later, p0_rdata=0x12345678.
- p1 writes addr 3 with wstrb=4'b0010 and data 0x0000AB00 over 0x12345678 → a subsequent read returns 0x1234AB78.
- Both ports request reads every cycle with rready=1 → with RR_EN, grants alternate 0,1,0,1; without it, p0 is granted every cycle and p1_ready stays 0.
- p0 read granted, p0_rready held 0 for 3 cycles → p0_rvalid and p0_rdata are stable, p0_ready=0 for a new p0 request, p1 is still served.
- resetn pulsed low while p1_rvalid=1 → p1_rvalid=0 immediately, and no RAM write occurs during reset.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared constants for the data RAM and its two-port arbiter.
//   RAM_DEPTH     : number of RAM words
//   ADDR_W/DATA_W : default word-address and data widths
//   STRB_W        : byte-strobe width (one bit per data byte)
//   P_CPU/P_DBG   : port index constants (CPU load/store = 0, debug/DMA = 1)
package data_ram_pkg;

    localparam int unsigned RAM_DEPTH = 32;
    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/data_ram_arb_resp.sv
// data_ram_arb_resp: per-port read response register.
// Captures RAM read data when a read is granted, holds it stable with rvalid
// set, and releases it on the edge where the requester asserts rready.
// Ports:
//   clk, resetn      : clock, async active-low reset
//   capture          : a read for this port is granted this cycle
//   cap_data         : RAM read data to capture
//   rready           : requester accepts the response
//   rvalid, rdata    : registered response
module data_ram_arb_resp #(
    parameter int unsigned DATA_W = data_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // A new capture has priority over release so that a consume-and-reissue
    // in the same cycle keeps rvalid high with the fresh data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (capture) begin
            rvalid <= 1'b1;
            rdata  <= cap_data;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_ram_arb.sv
// data_ram_arb: two-port arbiter/sequencer in front of the 32x32 data RAM
// (synchronous write, asynchronous read). At most one access is granted per
// cycle; reads return through a registered valid/ready response per port.
// Configuration macro:
//   DATA_RAM_ARB_RR_EN defined : round-robin on contention
//   undefined (default)        : fixed priority, port 0 wins contention
// Ports:
//   clk, resetn                : clock, async active-low reset
//   pN_req/we/wstrb/addr/wdata : port N request (N = 0 CPU, 1 debug/DMA)
//   pN_ready                   : combinational grant for port N
//   pN_rvalid/rdata/rready     : port N read response handshake
//   ram_wen/addr/wdata         : RAM drive (combinational from the grant)
//   ram_rdata                  : RAM asynchronous read data
module data_ram_arb #(
    parameter int unsigned ADDR_W = data_ram_pkg::ADDR_W,
    parameter int unsigned DATA_W = data_ram_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [DATA_W/8-1:0] p0_wstrb,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    output logic                p0_ready,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p0_rready,

    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic                p1_ready,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    input  logic                p1_rready,

    output logic [DATA_W/8-1:0] ram_wen,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    import data_ram_pkg::*;

    localparam int unsigned WSTRB_W = DATA_W / 8;

    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic last_grant;

    // A port may issue while idle or while its held response is being consumed.
    assign elig0 = p0_req & (~p0_rvalid | p0_rready);
    assign elig1 = p1_req & (~p1_rvalid | p1_rready);

    // Grant selection; nothing is granted while reset is asserted so a
    // request racing reset assertion never reaches the RAM.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetn) begin
            if (elig0 && elig1) begin
`ifdef DATA_RAM_ARB_RR_EN
                if (last_grant == P_CPU) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

`ifndef DATA_RAM_ARB_RR_EN
    // Fixed priority keeps last_grant for observability only.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // Last-grant register; reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= P_DBG;
        end else if (gnt0 || gnt1) begin
            last_grant <= gnt1 ? P_DBG : P_CPU;
        end
    end

    // RAM mux: follows the granted port, port 0 when idle; strobes only on a granted write.
    always_comb begin
        ram_wen   = '0;
        ram_addr  = p0_addr;
        ram_wdata = p0_wdata;
        if (gnt1) begin
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
            if (p1_we) begin
                ram_wen = p1_wstrb;
            end
        end else if (gnt0 && p0_we) begin
            ram_wen = p0_wstrb;
        end
    end

    data_ram_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp0 (
        .clk      (clk),
        .resetn   (resetn),
        .capture  (gnt0 & ~p0_we),
        .cap_data (ram_rdata),
        .rready   (p0_rready),
        .rvalid   (p0_rvalid),
        .rdata    (p0_rdata)
    );

    data_ram_arb_resp #(
        .DATA_W (DATA_W)
    ) u_resp1 (
        .clk      (clk),
        .resetn   (resetn),
        .capture  (gnt1 & ~p1_we),
        .cap_data (ram_rdata),
        .rready   (p1_rready),
        .rvalid   (p1_rvalid),
        .rdata    (p1_rdata)
    );

    logic [WSTRB_W-1:0] unused_wstrb_w;
    assign unused_wstrb_w = '0;

endmodule

// File: tb/tb_data_ram_arb.sv
// tb_data_ram_arb: directed self-checking bench for data_ram_arb with a
// behavioural 32x32 RAM (byte-enabled synchronous write, asynchronous read).
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled at that point, combinational outputs 1 unit after the inputs move.
module tb_data_ram_arb;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              resetn;
    logic              p0_req, p0_we, p0_rready;
    logic [3:0]        p0_wstrb;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready, p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req, p1_we, p1_rready;
    logic [3:0]        p1_wstrb;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready, p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [32];
    int n_checks;
    int n_errors;
    int bad_wr;

    data_ram_arb u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_wstrb  (p0_wstrb),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ready  (p0_ready),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_rready (p0_rready),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_wstrb  (p1_wstrb),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ready  (p1_ready),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_rready (p1_rready),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        if (!resetn && ram_wen != 4'b0000) bad_wr <= bad_wr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        logic exp1;

        n_checks  = 0;
        n_errors  = 0;
        bad_wr    = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        resetn    = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_wstrb = 4'h0; p0_addr = '0; p0_wdata = '0; p0_rready = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_wstrb = 4'h0; p1_addr = '0; p1_wdata = '0; p1_rready = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();

        // Reset state
        check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("rst_ram_wen", 32'(ram_wen), 32'd0);

        // p0 full-word write to addr 3
        p0_req = 1'b1; p0_we = 1'b1; p0_wstrb = 4'hF; p0_addr = 5'd3; p0_wdata = 32'h12345678;
        #1;
        check("wr0_ready", 32'(p0_ready), 32'd1);
        check("wr0_ram_wen", 32'(ram_wen), 32'hF);
        check("wr0_ram_addr", 32'(ram_addr), 32'd3);
        cyc();
        p0_req = 1'b0; p0_we = 1'b0;
        check("wr0_no_rvalid", 32'(p0_rvalid), 32'd0);

        // p0 read back addr 3
        p0_req = 1'b1; p0_addr = 5'd3;
        #1;
        check("rd0_ready", 32'(p0_ready), 32'd1);
        check("rd0_ram_wen", 32'(ram_wen), 32'd0);
        cyc();
        p0_req = 1'b0;
        check("rd0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rd0_rdata", p0_rdata, 32'h12345678);
        p0_rready = 1'b1;
        cyc();
        p0_rready = 1'b0;
        check("rd0_released", 32'(p0_rvalid), 32'd0);

        // p1 byte-1 write, then p0 reads same address on the next cycle
        p1_req = 1'b1; p1_we = 1'b1; p1_wstrb = 4'b0010; p1_addr = 5'd3; p1_wdata = 32'h0000AB00;
        #1;
        check("wr1_ready", 32'(p1_ready), 32'd1);
        check("wr1_ram_wen", 32'(ram_wen), 32'h2);
        cyc();
        p1_req = 1'b0; p1_we = 1'b0;
        p0_req = 1'b1; p0_addr = 5'd3;
        #1;
        check("haz_ready", 32'(p0_ready), 32'd1);
        cyc();
        p0_req = 1'b0;
        check("haz_rdata", p0_rdata, 32'h1234AB78);
        p0_rready = 1'b1;
        cyc();
        p0_rready = 1'b0;

        // Lone p1 read so port 1 holds the last grant
        p1_req = 1'b1; p1_addr = 5'd3;
        #1;
        check("rd1_ready", 32'(p1_ready), 32'd1);
        cyc();
        check("rd1_rdata", p1_rdata, 32'h1234AB78);

        // Contention: both ports read every cycle with rready high
        p0_req = 1'b1; p0_addr = 5'd3; p0_rready = 1'b1;
        p1_req = 1'b1; p1_addr = 5'd3; p1_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef DATA_RAM_ARB_RR_EN
            exp0 = ((i % 2) == 0);
`else
            exp0 = 1'b1;
`endif
            exp1 = ~exp0;
            check("cont_p0_ready", 32'(p0_ready), 32'(exp0));
            check("cont_p1_ready", 32'(p1_ready), 32'(exp1));
            cyc();
            check("cont_p0_rvalid", 32'(p0_rvalid), 32'(exp0));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        cyc();
        p0_rready = 1'b0; p1_rready = 1'b0;
        check("cont_drain0", 32'(p0_rvalid), 32'd0);
        check("cont_drain1", 32'(p1_rvalid), 32'd0);

        // p0 response stalled 3 cycles while p1 is served
        p0_req = 1'b1; p0_addr = 5'd3;
        #1;
        check("st_grant", 32'(p0_ready), 32'd1);
        cyc();
        p0_addr = 5'd7;
        p1_req = 1'b1; p1_we = 1'b1; p1_wstrb = 4'hF; p1_addr = 5'd7; p1_wdata = 32'hCAFEF00D;
        #1;
        check("st1_p0_ready", 32'(p0_ready), 32'd0);
        check("st1_p1_ready", 32'(p1_ready), 32'd1);
        cyc();
        check("st2_rvalid", 32'(p0_rvalid), 32'd1);
        check("st2_rdata", p0_rdata, 32'h1234AB78);
        p1_we = 1'b0;
        #1;
        check("st2_p0_ready", 32'(p0_ready), 32'd0);
        check("st2_p1_ready", 32'(p1_ready), 32'd1);
        cyc();
        check("st3_rvalid", 32'(p0_rvalid), 32'd1);
        check("st3_rdata", p0_rdata, 32'h1234AB78);
        check("st3_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("st3_p1_rdata", p1_rdata, 32'hCAFEF00D);
        p1_req = 1'b0;
        #1;
        check("st3_p0_ready", 32'(p0_ready), 32'd0);
        cyc();
        check("st4_rdata", p0_rdata, 32'h1234AB78);
        // Consume and reissue in the same cycle
        p0_rready = 1'b1;
        #1;
        check("b2b_ready", 32'(p0_ready), 32'd1);
        cyc();
        check("b2b_rvalid", 32'(p0_rvalid), 32'd1);
        check("b2b_rdata", p0_rdata, 32'hCAFEF00D);
        p0_req = 1'b0; p0_rready = 1'b0;

        // Reset while p1 response pending, with a p0 write racing it
        p0_req = 1'b1; p0_we = 1'b1; p0_wstrb = 4'hF; p0_addr = 5'd7; p0_wdata = 32'hDEADBEEF;
        resetn = 1'b0;
        #1;
        check("arst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("arst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("arst_p0_rdata", p0_rdata, 32'h0);
        check("arst_ram_wen", 32'(ram_wen), 32'd0);
        check("arst_p0_ready", 32'(p0_ready), 32'd0);
        cyc();
        resetn = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0;
        cyc();
        p0_req = 1'b1; p0_addr = 5'd7;
        cyc();
        p0_req = 1'b0;
        check("arst_mem_kept", p0_rdata, 32'hCAFEF00D);
        check("arst_no_write", 32'(bad_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
